// File: rtl/prog_sequencer.sv
// Program memory plus issue/capture sequencer driving the mini RISC-V core's instruction port.
// Optional watchdog abort is compiled in with PROG_SEQUENCER_WATCHDOG_EN.
module prog_sequencer #(
    parameter int DEPTH = 16,
    parameter int PCW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_valid,
    input  logic [7:0]     load_byte,
    output logic           load_ready,
    input  logic           start,
    output logic [15:0]    instr,
    input  logic [7:0]     result,
    output logic           res_valid,
    output logic [7:0]     res_data,
    output logic [PCW-1:0] pc,
    output logic           busy,
    output logic           done,
    output logic           timeout
);
    localparam logic [15:0]    NOP      = 16'h0003;
    localparam logic [15:0]    HALT     = 16'hFFFF;
    localparam logic [PCW-1:0] LAST_PC  = PCW'(DEPTH - 1);
    localparam logic [5:0]     PTR_MASK = 6'(2 * DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [5:0]     ptr_q, ptr_d;
    logic           res_valid_q, res_valid_d;
    logic [7:0]     res_data_q, res_data_d;
    logic           timeout_q, timeout_d;
    logic           wr_en;
    logic [15:0]    mem_q [DEPTH];
    logic [15:0]    cur_w;
    logic [PCW-1:0] pc_inc1, pc_inc2;
    logic           is_halt, is_branch, is_output;
`ifdef PROG_SEQUENCER_WATCHDOG_EN
    logic [7:0]     wd_q, wd_d;
`endif

    assign cur_w     = mem_q[pc_q];
    assign pc_inc1   = pc_q + PCW'(1);
    assign pc_inc2   = pc_q + PCW'(2);
    assign is_halt   = (cur_w == HALT);
    assign is_branch = (cur_w[1:0] == 2'b11) && (cur_w[15:13] == 3'b011);
    // HALT has bit 11 set, so it never decodes as an OUTPUT.
    assign is_output = (cur_w[1:0] == 2'b11) &&
                       ((cur_w[15:13] == 3'b000) || ((cur_w[15:13] == 3'b111) && !cur_w[11]));

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ptr_d       = ptr_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        timeout_d   = timeout_q;
        wr_en       = 1'b0;
`ifdef PROG_SEQUENCER_WATCHDOG_EN
        wd_d        = wd_q;
`endif
        case (state_q)
            S_RUN: begin
                if (is_halt) begin
                    state_d = S_DONE;
                end else if (is_branch) begin
                    // The word after a branch is its target and is skipped either way.
                    if (pc_q == LAST_PC) begin
                        state_d = S_DONE;
                    end else if (result[0]) begin
                        pc_d = mem_q[pc_inc1][PCW-1:0];
                    end else if (pc_inc2 < pc_q) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d = pc_inc2;
                    end
                end else begin
                    if (is_output) begin
                        res_valid_d = 1'b1;
                        res_data_d  = result;
                    end
                    if (pc_q == LAST_PC) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d = pc_inc1;
                    end
                end
`ifdef PROG_SEQUENCER_WATCHDOG_EN
                wd_d = wd_q + 8'd1;
                if ((state_d == S_RUN) && (wd_d == 8'hFF)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: begin
                if (load_valid) begin
                    wr_en = 1'b1;
                    ptr_d = (ptr_q + 6'd1) & PTR_MASK;
                end
                if (start) begin
                    state_d   = S_RUN;
                    pc_d      = '0;
                    ptr_d     = '0;
                    timeout_d = 1'b0;
`ifdef PROG_SEQUENCER_WATCHDOG_EN
                    wd_d      = 8'd0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            timeout_q   <= 1'b0;
`ifdef PROG_SEQUENCER_WATCHDOG_EN
            wd_q        <= 8'd0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= HALT;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            timeout_q   <= timeout_d;
`ifdef PROG_SEQUENCER_WATCHDOG_EN
            wd_q        <= wd_d;
`endif
            if (wr_en) begin
                if (ptr_q[0]) begin
                    mem_q[ptr_q[PCW:1]][15:8] <= load_byte;
                end else begin
                    mem_q[ptr_q[PCW:1]][7:0] <= load_byte;
                end
            end
        end
    end

    assign instr      = ((state_q == S_RUN) && !is_halt) ? cur_w : NOP;
    assign pc         = pc_q;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign load_ready = (state_q != S_RUN);
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign timeout    = timeout_q;

endmodule
